// File: rtl/sprite_line_renderer.sv
// sprite_line_renderer
//   Renders one scanline of sprites into one of two line buffers while the
//   other buffer is read by the display. Each render clears the target
//   buffer, then scans every attribute slot. For each slot that covers the
//   line, it fetches 32 pixels from the sprite ROM and writes the
//   non-transparent ones. Higher slots are drawn later, so they win.
//
// Parameters
//   NSLOT    number of attribute slots (power of two)
//   HACTIVE  visible pixels per line (at most 1024)
//
// Ports
//   clk, reset_n            clock; synchronous active-low reset
//   attr_we/addr/data       attribute write {n_sprite[25:20], y[19:10], x[9:0]}
//   line_start, next_line   start rendering next_line (restarts if busy)
//   disp_odd, rd_x          display read side; color_code_e/o, select
//   n_sprite, line, pixel   sprite ROM request (0 outside FETCH)
//   color_code              ROM data, one cycle after the request
//   busy, overrun           render active; sticky restart-while-busy flag
//
// Config macro SPRITE_OVERRUN_EN: when defined, overrun is a sticky register.
//   When undefined, overrun is tied to 0.
module sprite_line_renderer #(
  parameter int NSLOT   = 16,
  parameter int HACTIVE = 640
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     attr_we,
  input  logic [$clog2(NSLOT)-1:0] attr_addr,
  input  logic [25:0]              attr_data,
  input  logic                     line_start,
  input  logic [9:0]               next_line,
  input  logic                     disp_odd,
  input  logic [9:0]               rd_x,
  output logic [5:0]               n_sprite,
  output logic [9:0]               line,
  output logic [5:0]               pixel,
  input  logic [3:0]               color_code,
  output logic [3:0]               color_code_o,
  output logic [3:0]               color_code_e,
  output logic                     select,
  output logic                     busy,
  output logic                     overrun
);
  localparam int SW = $clog2(NSLOT);

  typedef enum logic [2:0] {IDLE, CLEAR, SCAN, FETCH, DRAIN} state_t;

  state_t         state_q, state_d;
  logic [9:0]     cnt_q, cnt_d;          // clear address in CLEAR, pixel in FETCH
  logic [SW-1:0]  slot_q, slot_d;
  logic [9:0]     line_q, line_d;        // line being rendered; bit 0 = target buffer
  logic [5:0]     lat_n_q, lat_n_d;      // slot values frozen at SCAN
  logic [4:0]     lat_row_q, lat_row_d;
  logic [9:0]     lat_x_q, lat_x_d;
  logic           wr_vld_q, wr_vld_d;    // ROM request issued last cycle
  logic [10:0]    wr_addr_q, wr_addr_d;
  logic [25:0]    attr_q [NSLOT];
  logic [3:0]     ce_q, co_q;
  logic           sel_q;

  logic [3:0]     lbuf_e [HACTIVE];
  logic [3:0]     lbuf_o [HACTIVE];

  // Current slot decode for SCAN; compares are 11-bit so y+32 never wraps.
  logic [25:0] cur;
  logic [5:0]  cur_n;
  logic [9:0]  cur_y, cur_x;
  logic        hit, last_slot;
  assign cur       = attr_q[slot_q];
  assign cur_n     = cur[25:20];
  assign cur_y     = cur[19:10];
  assign cur_x     = cur[9:0];
  assign hit       = (cur_n != 6'd0) && ({1'b0, line_q} >= {1'b0, cur_y}) &&
                     ({1'b0, line_q} < ({1'b0, cur_y} + 11'd32));
  assign last_slot = &slot_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    slot_d    = slot_q;
    line_d    = line_q;
    lat_n_d   = lat_n_q;
    lat_row_d = lat_row_q;
    lat_x_d   = lat_x_q;
    wr_vld_d  = 1'b0;
    wr_addr_d = {1'b0, lat_x_q} + {6'd0, cnt_q[4:0]};
    case (state_q)
      CLEAR: begin
        if (cnt_q == 10'(HACTIVE - 1)) begin
          state_d = SCAN;
          slot_d  = '0;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      SCAN: begin
        if (hit) begin
          state_d   = FETCH;
          cnt_d     = '0;
          lat_n_d   = cur_n;
          lat_row_d = line_q[4:0] - cur_y[4:0];
          lat_x_d   = cur_x;
        end else if (last_slot) begin
          state_d = IDLE;
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      FETCH: begin
        wr_vld_d = 1'b1;
        if (cnt_q[4:0] == 5'd31) state_d = DRAIN;
        else                     cnt_d   = cnt_q + 10'd1;
      end
      DRAIN: begin
        // The write for pixel 31 lands during this cycle.
        if (last_slot) begin
          state_d = IDLE;
        end else begin
          state_d = SCAN;
          slot_d  = slot_q + 1'b1;
        end
      end
      default: ;
    endcase
    if (line_start) begin
      state_d  = CLEAR;
      cnt_d    = '0;
      line_d   = next_line;
      wr_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      slot_q    <= '0;
      line_q    <= '0;
      lat_n_q   <= '0;
      lat_row_q <= '0;
      lat_x_q   <= '0;
      wr_vld_q  <= 1'b0;
      wr_addr_q <= '0;
      ce_q      <= '0;
      co_q      <= '0;
      sel_q     <= 1'b0;
      for (int i = 0; i < NSLOT; i++) attr_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      slot_q    <= slot_d;
      line_q    <= line_d;
      lat_n_q   <= lat_n_d;
      lat_row_q <= lat_row_d;
      lat_x_q   <= lat_x_d;
      wr_vld_q  <= wr_vld_d;
      wr_addr_q <= wr_addr_d;
      ce_q      <= ({1'b0, rd_x} < 11'(HACTIVE)) ? lbuf_e[rd_x] : 4'd0;
      co_q      <= ({1'b0, rd_x} < 11'(HACTIVE)) ? lbuf_o[rd_x] : 4'd0;
      sel_q     <= disp_odd;
      if (attr_we) attr_q[attr_addr] <= attr_data;
    end
  end

  // Single write port into the target buffer: clear or sprite pixel.
  // Reset and a restarting line_start both cancel the write at that edge.
  // This keeps an aborted render from touching the buffer now on display.
  logic       lb_we;
  logic [9:0] lb_addr;
  logic [3:0] lb_data;
  always_comb begin
    lb_we   = 1'b0;
    lb_addr = cnt_q;
    lb_data = 4'd0;
    if (state_q == CLEAR) begin
      lb_we = 1'b1;
    end else if (wr_vld_q && (color_code != 4'd0) && (wr_addr_q < 11'(HACTIVE))) begin
      lb_we   = 1'b1;
      lb_addr = wr_addr_q[9:0];
      lb_data = color_code;
    end
    if (!reset_n || line_start) lb_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (lb_we) begin
      if (line_q[0]) lbuf_o[lb_addr] <= lb_data;
      else           lbuf_e[lb_addr] <= lb_data;
    end
  end

  assign busy         = (state_q != IDLE);
  assign n_sprite     = (state_q == FETCH) ? lat_n_q : 6'd0;
  assign line         = (state_q == FETCH) ? {5'd0, lat_row_q} : 10'd0;
  assign pixel        = (state_q == FETCH) ? {1'b0, cnt_q[4:0]} : 6'd0;
  assign color_code_e = ce_q;
  assign color_code_o = co_q;
  assign select       = sel_q;

`ifdef SPRITE_OVERRUN_EN
  logic overrun_q;
  always_ff @(posedge clk) begin
    if (!reset_n)                overrun_q <= 1'b0;
    else if (line_start && busy) overrun_q <= 1'b1;
  end
  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_line_renderer.sv
module tb_sprite_line_renderer;
  localparam int NSLOT   = 16;
  localparam int HACTIVE = 640;

  logic       clk = 1'b0, reset_n = 1'b0, attr_we = 1'b0;
  logic [3:0] attr_addr = '0;
  logic [25:0] attr_data = '0;
  logic       line_start = 1'b0;
  logic [9:0] next_line = '0, rd_x = '0;
  logic       disp_odd = 1'b0;
  logic [5:0] n_sprite, pixel;
  logic [9:0] line;
  logic [3:0] color_code = '0, color_code_o, color_code_e;
  logic       select, busy, overrun;

  always #5 clk = ~clk;

  sprite_line_renderer #(.NSLOT(NSLOT), .HACTIVE(HACTIVE)) dut (
    .clk(clk), .reset_n(reset_n), .attr_we(attr_we), .attr_addr(attr_addr),
    .attr_data(attr_data), .line_start(line_start), .next_line(next_line),
    .disp_odd(disp_odd), .rd_x(rd_x), .n_sprite(n_sprite), .line(line),
    .pixel(pixel), .color_code(color_code), .color_code_o(color_code_o),
    .color_code_e(color_code_e), .select(select), .busy(busy), .overrun(overrun)
  );

  // Sprite ROM model: synchronous, with some transparent texels.
  function automatic logic [3:0] rom(int n, int row, int pix);
    if ((pix + n) % 5 == 0) return 4'd0;
    return 4'((n * 5 + row * 3 + pix * 7) & 15);
  endfunction
  always @(posedge clk) color_code <= rom(int'(n_sprite), int'(line), int'(pixel));

  int checks = 0, errors = 0;
  int sh_n[NSLOT], sh_y[NSLOT], sh_x[NSLOT];
  int mb[2][HACTIVE];
  int exp_req[$], got_req[$];
  int idle_bad;

  `ifdef SPRITE_OVERRUN_EN
  localparam int OVR_EXP = 1;
  `else
  localparam int OVR_EXP = 0;
  `endif

  typedef struct { int slot; int n; int y; int x; int l; int cyc; } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic write_attr(input int s, input int n, input int y, input int x);
    attr_we = 1'b1; attr_addr = 4'(s); attr_data = {6'(n), 10'(y), 10'(x)};
    @(negedge clk);
    attr_we = 1'b0;
    sh_n[s] = n; sh_y[s] = y; sh_x[s] = x;
  endtask

  task automatic clear_attrs();
    for (int s = 0; s < NSLOT; s++) write_attr(s, 0, 0, 0);
  endtask

  task automatic start_line(input int l);
    line_start = 1'b1; next_line = 10'(l);
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0; idle_bad = 0; got_req.delete();
    while (busy && cyc < 3000) begin
      if (n_sprite != 0) got_req.push_back(int'(n_sprite) * 4096 + int'(line) * 64 + int'(pixel));
      else if (line != 0 || pixel != 0) idle_bad++;
      cyc++;
      @(negedge clk);
    end
  endtask

  // Reference: what the line must look like, from the attribute shadow.
  task automatic model_render(input int l, output int hits);
    int par, row, a;
    logic [3:0] code;
    par = l & 1; hits = 0; exp_req.delete();
    for (int c = 0; c < HACTIVE; c++) mb[par][c] = 0;
    for (int s = 0; s < NSLOT; s++) begin
      if (sh_n[s] != 0 && l >= sh_y[s] && l < sh_y[s] + 32) begin
        hits++; row = l - sh_y[s];
        for (int p = 0; p < 32; p++) begin
          exp_req.push_back(sh_n[s] * 4096 + row * 64 + p);
          code = rom(sh_n[s], row, p);
          a = sh_x[s] + p;
          if (code != 0 && a < HACTIVE) mb[par][a] = int'(code);
        end
      end
    end
  endtask

  task automatic check_buf(input int par, input string name);
    int mism, first, fa, fe, act;
    mism = 0; first = -1; fa = 0; fe = 0;
    disp_odd = par[0];
    for (int c = 0; c < HACTIVE; c++) begin
      rd_x = 10'(c);
      @(negedge clk);
      act = par[0] ? int'(color_code_o) : int'(color_code_e);
      if (act != mb[par][c]) begin
        mism++;
        if (first < 0) begin first = c; fa = act; fe = mb[par][c]; end
      end
    end
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL %s_buf: %0d columns differ, col %0d got %0d expected %0d", name, mism, first, fa, fe);
    end
    check({name, "_sel"}, int'(select), par);
  endtask

  task automatic finish_render(input int l, input string name, output int cyc);
    int hits, ok;
    model_render(l, hits);
    wait_idle(cyc);
    check({name, "_cyc"}, cyc, HACTIVE + NSLOT + 33 * hits);
    ok = (got_req.size() == exp_req.size());
    if (ok) foreach (exp_req[i]) if (got_req[i] != exp_req[i]) ok = 0;
    check({name, "_reqs"}, ok, 1);
    check({name, "_idle_zero"}, idle_bad, 0);
    check_buf(l & 1, name);
  endtask

  task automatic run_render(input int l, input string name, output int cyc);
    start_line(l);
    finish_render(l, name, cyc);
  endtask

  initial begin
    int cyc, k, hits, l;
    tbl[0] = '{0, 1, 100, 200, 110, 689};   // basic hit, row 10
    tbl[1] = '{3, 2, 50, 620, 50, 689};     // right-edge clip
    tbl[2] = '{0, 1, 100, 200, 132, 656};   // y+32: miss
    tbl[3] = '{7, 5, 0, 0, 31, 689};        // last row, odd buffer
    tbl[4] = '{15, 63, 1000, 10, 1023, 689};// top of range, no wrap
    tbl[5] = '{4, 0, 10, 10, 10, 656};      // disabled slot
    tbl[6] = '{1, 9, 200, 5, 199, 656};     // one line above sprite

    disp_odd = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_nsprite", int'(n_sprite), 0);
    check("rst_line", int'(line), 0);
    check("rst_pixel", int'(pixel), 0);
    check("rst_cce", int'(color_code_e), 0);
    check("rst_cco", int'(color_code_o), 0);
    check("rst_select", int'(select), 0);
    reset_n = 1'b1; disp_odd = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      clear_attrs();
      write_attr(tbl[i].slot, tbl[i].n, tbl[i].y, tbl[i].x);
      run_render(tbl[i].l, $sformatf("vec%0d", i), cyc);
      check($sformatf("vec%0d_tblcyc", i), cyc, tbl[i].cyc);
    end

    // Reads beyond the visible width return 0.
    disp_odd = 1'b0;
    rd_x = 10'd640; @(negedge clk);
    check("rd_640_e", int'(color_code_e), 0);
    check("rd_640_o", int'(color_code_o), 0);
    rd_x = 10'd1023; @(negedge clk);
    check("rd_1023_o", int'(color_code_o), 0);

    // Overlap: slot 5 drawn after slot 2.
    clear_attrs();
    write_attr(2, 3, 20, 300);
    write_attr(5, 4, 20, 300);
    run_render(25, "overlap", cyc);
    disp_odd = 1'b1; rd_x = 10'd300; @(negedge clk);
    check("overlap_col300", int'(color_code_o), 3);

    // Restart while busy.
    clear_attrs();
    write_attr(0, 1, 100, 200);
    start_line(110);
    check("ovr_before", int'(overrun), 0);
    repeat (49) @(negedge clk);
    start_line(111);
    check("ovr_set", int'(overrun), OVR_EXP);
    finish_render(111, "restart", cyc);
    check("ovr_sticky", int'(overrun), OVR_EXP);

    // Reset during FETCH.
    start_line(110);
    k = 0;
    while (n_sprite == 0 && k < 2000) begin @(negedge clk); k++; end
    check("rst_reach_fetch", int'(n_sprite), 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("rstf_busy", int'(busy), 0);
    check("rstf_nsprite", int'(n_sprite), 0);
    check("rstf_overrun", int'(overrun), 0);
    reset_n = 1'b1;
    for (int s = 0; s < NSLOT; s++) begin sh_n[s] = 0; sh_y[s] = 0; sh_x[s] = 0; end
    run_render(110, "post_rst", cyc);
    check("post_rst_tblcyc", cyc, 656);

    // Randomized slots against the model.
    for (int it = 0; it < 6; it++) begin
      l = $urandom_range(40, 1023);
      for (int s = 0; s < NSLOT; s++)
        write_attr(s, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 63),
                   l - $urandom_range(0, 40), $urandom_range(0, 659));
      model_render(l, hits);
      run_render(l, $sformatf("rand%0d", it), cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sprite_line_renderer.md
SPRITE_LINE_RENDERER -- requirements
Module: sprite_line_renderer

Interface
REQ-001 Parameter NSLOT, default 16, number of sprite attribute slots (power of two).
REQ-002 Parameter HACTIVE, default 640, visible pixels per line.
REQ-003 clk  input  1  sole clock, all logic rising-edge; reset is synchronous and active-low.
REQ-004 reset_n  input  1  synchronous active-low reset.
REQ-005 attr_we  input  1  attribute-table write strobe.
REQ-006 attr_addr  input  log2(NSLOT)  slot index written.
REQ-007 attr_data  input  26  {n_sprite[25:20], y[19:10], x[9:0]}; n_sprite 0 = slot disabled.
REQ-008 line_start  input  1  one-cycle pulse: begin rendering next_line.
REQ-009 next_line  input  10  scanline to render, sampled on line_start.
REQ-010 disp_odd  input  1  parity of line currently displayed.
REQ-011 rd_x  input  10  display read column.
REQ-012 n_sprite  output  6  sprite ROM select.
REQ-013 line  output  10  row within sprite, 0..31.
REQ-014 pixel  output  6  column within sprite, 0..31.
REQ-015 color_code  input  4  sprite ROM data, valid one cycle after n_sprite/line/pixel.
REQ-016 color_code_o, color_code_e  output  4 each  odd/even line-buffer read data.
REQ-017 select  output  1  palette select, 1 = odd buffer.
REQ-018 busy  output  1  render in progress.
REQ-019 overrun  output  1  sticky flag, line_start arrived while busy.

Function
REQ-020 Two HACTIVE x 4-bit line buffers: even and odd; render target = buffer of parity next_line[0]; the other buffer is read-only for display.
REQ-021 Display read: color_code_e/o = even/odd buffer[rd_x], registered, 1-cycle latency; select = disp_odd registered 1 cycle; rd_x >= HACTIVE returns 0.
REQ-022 FSM states IDLE, CLEAR, SCAN, FETCH, DRAIN; line_start in any state -> CLEAR with next_line captured, clear address 0.
REQ-023 CLEAR: writes 0 to target buffer one address per cycle, 0..HACTIVE-1, then SCAN at slot 0.
REQ-024 SCAN: one cycle per slot; hit when n_sprite!=0 and y <= L < y+32 (11-bit compare, no wrap); hit -> FETCH, miss -> next slot; after slot NSLOT-1 -> IDLE.
REQ-025 FETCH: drives n_sprite=slot's n_sprite, line=L-y, pixel=0..31 on consecutive cycles; after pixel 31 -> DRAIN (1 cycle) then next slot or IDLE.
REQ-026 Write of returned color_code occurs one cycle after its request, at address x+pixel (11-bit sum); suppressed when color_code==0 (transparent) or address >= HACTIVE.
REQ-027 Priority: higher slot index written later and overwrites lower.
REQ-028 Worst-case render time HACTIVE + NSLOT*34 cycles (1184 at defaults).
REQ-029 Outputs n_sprite/line/pixel are 0 outside FETCH.
REQ-030 busy = 1 in CLEAR, SCAN, FETCH, DRAIN.
REQ-031 Attribute writes take effect immediately; a slot written during its own FETCH uses the values latched at its SCAN.
REQ-032 line_start while busy aborts current render, starts new one, sets overrun (when enabled).

Reset
REQ-033 On reset_n=0 at clk edge: state IDLE, busy 0, overrun 0, n_sprite/line/pixel 0, color_code_o/e 0, select 0, all attribute slots n_sprite=0, x=0, y=0.
REQ-034 Line-buffer contents are not reset; first render clears its target.
REQ-035 Reset mid-render abandons it; no further buffer writes.

Configuration
REQ-036 Macro SPRITE_OVERRUN_EN defined: overrun implemented per REQ-019/REQ-032, cleared only by reset.
REQ-037 Macro SPRITE_OVERRUN_EN undefined: overrun tied 0, no overrun register; abort/restart behaviour unchanged.

Verification
REQ-038 Slot 0 = {n=1, y=100, x=200}, line_start next_line=110 -> request line=10, pixel 0..31; even buffer[200..231] = ROM row 10 non-zero codes, else 0.
REQ-039 Slot 3 x=620, next_line=y -> only columns 620..639 written; no write at >=640.
REQ-040 Slots 2 and 5 overlapping at x=300, both codes non-zero -> buffer[300] equals slot 5 code.
REQ-041 next_line=y+32 -> SCAN miss, target buffer all 0, busy low after 640+16 cycles.
REQ-042 line_start again 50 cycles into render -> overrun=1, new line rendered correctly; without SPRITE_OVERRUN_EN overrun stays 0.
REQ-043 reset_n low during FETCH -> next cycle busy=0, n_sprite=0, all slots disabled.
